// File: rtl/fft64_stage_sequencer.sv
// Stage/butterfly sequencer for a 64-point radix-2 DIT FFT; tracks PIPE_LAT-deep writebacks and enforces a stage barrier.
// Define FFT_SEQ_TWCLASS_EN to decode tw_class from tw_idx; otherwise tw_class is the general path (3).
module fft64_stage_sequencer #(
  parameter int PIPE_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       bf_valid,
  input  logic       bf_ready,
  output logic [5:0] rd_addr_a,
  output logic [5:0] rd_addr_b,
  output logic [4:0] tw_idx,
  output logic [1:0] tw_class,
  output logic [2:0] stage,
  output logic       wb_en,
  output logic [5:0] wr_addr_a,
  output logic [5:0] wr_addr_b
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [4:0] j_q, j_d;
  logic [3:0] inflight_q, inflight_d;
  logic [5:0] rd_a_q, rd_b_q;
  logic [4:0] tw_idx_q;
  logic [1:0] tw_class_q;
  logic       accept, load;

  logic [5:0] span, pos, grp, kx, nxt_a, nxt_b;
  logic [4:0] nxt_k;
  logic [1:0] nxt_cls;

  logic [PIPE_LAT-1:0] wb_vld_q;
  logic [5:0]          wb_a_q [PIPE_LAT];
  logic [5:0]          wb_b_q [PIPE_LAT];

  assign accept = bf_valid & bf_ready;
  assign wb_en  = wb_vld_q[PIPE_LAT-1];

  always_comb begin
    inflight_d = inflight_q + {3'd0, accept} - {3'd0, wb_en};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // DRAIN looks at the post-writeback count so the next stage issues right after the last wb_en.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        stage_d = 3'd0;
        j_d     = 5'd0;
        load    = 1'b1;
      end
      ISSUE: if (accept) begin
        if (j_q == 5'd31) begin
          state_d = DRAIN;
        end else begin
          j_d  = j_q + 5'd1;
          load = 1'b1;
        end
      end
      DRAIN: if (inflight_d == 4'd0) begin
        if (stage_q == 3'd5) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
          stage_d = stage_q + 3'd1;
          j_d     = 5'd0;
          load    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    bf_valid = (state_q == ISSUE);
  end

  always_comb begin
    span  = 6'd1 << stage_d;
    pos   = {1'b0, j_d} & (span - 6'd1);
    grp   = {1'b0, j_d} >> stage_d;
    nxt_a = (grp << (stage_d + 3'd1)) | pos;
    nxt_b = nxt_a + span;
    kx    = pos << (3'd5 - stage_d);
    nxt_k = kx[4:0];
  end

`ifdef FFT_SEQ_TWCLASS_EN
  always_comb begin
    case (nxt_k)
      5'd0:         nxt_cls = 2'd0;
      5'd16:        nxt_cls = 2'd1;
      5'd8, 5'd24:  nxt_cls = 2'd2;
      default:      nxt_cls = 2'd3;
    endcase
  end
`else
  assign nxt_cls = 2'd3;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q    <= 3'd0;
      j_q        <= 5'd0;
      inflight_q <= 4'd0;
      rd_a_q     <= 6'd0;
      rd_b_q     <= 6'd0;
      tw_idx_q   <= 5'd0;
      tw_class_q <= 2'd0;
    end else begin
      stage_q    <= stage_d;
      j_q        <= j_d;
      inflight_q <= inflight_d;
      if (load) begin
        rd_a_q     <= nxt_a;
        rd_b_q     <= nxt_b;
        tw_idx_q   <= nxt_k;
        tw_class_q <= nxt_cls;
      end
    end
  end

  // Idle slots shift in zeros so wr_addr_* read 0 whenever wb_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        wb_a_q[i] <= 6'd0;
        wb_b_q[i] <= 6'd0;
      end
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        wb_vld_q[i] <= wb_vld_q[i-1];
        wb_a_q[i]   <= wb_a_q[i-1];
        wb_b_q[i]   <= wb_b_q[i-1];
      end
      wb_vld_q[0] <= accept;
      wb_a_q[0]   <= accept ? rd_a_q : 6'd0;
      wb_b_q[0]   <= accept ? rd_b_q : 6'd0;
    end
  end

  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_idx    = tw_idx_q;
  assign tw_class  = tw_class_q;
  assign stage     = stage_q;
  assign wr_addr_a = wb_a_q[PIPE_LAT-1];
  assign wr_addr_b = wb_b_q[PIPE_LAT-1];

endmodule
